// File: rtl/mul_batch_tdm.sv
// mul_batch_tdm: time-multiplexed group multiplier.
// One weight is multiplied against a GROUP_SIZE-wide activation group using
// NUM_MULS physical multipliers over GROUP_SIZE/NUM_MULS cycles.
// Each weight is reused for num_reads_per_iter groups, and a run lasts num_iters weights.
// Optional build macro: MUL_BATCH_STATS_EN adds the stat_beats and stat_stalls counters.
//
// state  | meaning
// IDLE   | no run active, all handshakes low
// LOAD_W | waiting for a weight
// LOAD_A | waiting for an activation group (the weight is held)
// MUL    | one lane slice per cycle goes into the result register
// OUT    | result presented until the downstream stage takes it
module mul_batch_tdm #(
    parameter int GROUP_SIZE             = 4,
    parameter int DATA_WIDTH             = 8,
    parameter int NUM_MULS               = 2,
    parameter int LOG_MAX_ITERS          = 16,
    parameter int LOG_MAX_READS_PER_ITER = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                configure,
    input  logic [LOG_MAX_ITERS-1:0]            num_iters,
    input  logic [LOG_MAX_READS_PER_ITER-1:0]   num_reads_per_iter,
    input  logic                                signed_mode,
    input  logic [GROUP_SIZE*DATA_WIDTH-1:0]    act_data_in,
    input  logic                                act_valid_in,
    output logic                                act_avail_out,
    input  logic [DATA_WIDTH-1:0]               weight_data_in,
    input  logic                                weight_valid_in,
    output logic                                weight_avail_out,
    output logic [GROUP_SIZE*2*DATA_WIDTH-1:0]  data_out,
    output logic                                valid_out,
    input  logic                                avail_in,
    output logic                                done_out
`ifdef MUL_BATCH_STATS_EN
    ,
    output logic [31:0]                         stat_beats,
    output logic [31:0]                         stat_stalls
`endif
);

    localparam int STEPS = GROUP_SIZE / NUM_MULS;
    localparam int LW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(STEPS - 1);
    localparam logic [LW-1:0] LANE_ONE  = LW'(1);
    localparam logic [LOG_MAX_ITERS-1:0]          ITER_ONE = LOG_MAX_ITERS'(1);
    localparam logic [LOG_MAX_READS_PER_ITER-1:0] READ_ONE = LOG_MAX_READS_PER_ITER'(1);

    generate
        if (GROUP_SIZE % NUM_MULS != 0) begin : g_bad_num_muls
            $error("NUM_MULS must divide GROUP_SIZE");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_A, MUL, OUT} state_t;

    state_t                              state, state_nxt;
    logic                                done_nxt;
    logic [LOG_MAX_ITERS-1:0]            iters_cfg, iter_cnt;
    logic [LOG_MAX_READS_PER_ITER-1:0]   reads_cfg, read_cnt;
    logic                                sm_cfg;
    logic [DATA_WIDTH-1:0]               weight_reg;
    logic [GROUP_SIZE*DATA_WIDTH-1:0]    act_reg;
    logic [LW-1:0]                       lane_idx;
    logic [DATA_WIDTH-1:0]               op_a [NUM_MULS];
    logic [2*DATA_WIDTH-1:0]             prod [NUM_MULS];
    logic                                w_xfer, a_xfer, o_xfer, last_read, last_iter;

    assign w_xfer    = weight_valid_in & weight_avail_out;
    assign a_xfer    = act_valid_in & act_avail_out;
    assign o_xfer    = valid_out & avail_in;
    assign last_read = (read_cnt == reads_cfg - READ_ONE);
    assign last_iter = (iter_cnt == iters_cfg - ITER_ONE);

    // Lane-slice multipliers: operands are extended to full product width, so the
    // low 2*DATA_WIDTH bits are exact for both signed and unsigned operands.
    always_comb begin
        for (int j = 0; j < NUM_MULS; j++) begin
            op_a[j] = act_reg[(int'(lane_idx) * NUM_MULS + j) * DATA_WIDTH +: DATA_WIDTH];
            prod[j] = {{DATA_WIDTH{sm_cfg & op_a[j][DATA_WIDTH-1]}}, op_a[j]}
                    * {{DATA_WIDTH{sm_cfg & weight_reg[DATA_WIDTH-1]}}, weight_reg};
        end
    end

    // Next-state and done decode; configure overrides every state.
    always_comb begin
        state_nxt = state;
        done_nxt  = 1'b0;
        if (configure) begin
            if (num_iters == '0 || num_reads_per_iter == '0) begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
            end else begin
                state_nxt = LOAD_W;
            end
        end else begin
            case (state)
                LOAD_W: if (w_xfer) state_nxt = LOAD_A;
                LOAD_A: if (a_xfer) state_nxt = MUL;
                MUL:    if (lane_idx == LAST_LANE) state_nxt = OUT;
                OUT: begin
                    if (o_xfer) begin
                        if (!last_read) begin
                            state_nxt = LOAD_A;
                        end else if (last_iter) begin
                            state_nxt = IDLE;
                            done_nxt  = 1'b1;
                        end else begin
                            state_nxt = LOAD_W;
                        end
                    end
                end
                default: state_nxt = state;
            endcase
        end
    end

    // State register, registered handshakes and the datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= IDLE;
            done_out         <= 1'b0;
            weight_avail_out <= 1'b0;
            act_avail_out    <= 1'b0;
            valid_out        <= 1'b0;
            data_out         <= '0;
            iters_cfg        <= '0;
            reads_cfg        <= '0;
            sm_cfg           <= 1'b0;
            iter_cnt         <= '0;
            read_cnt         <= '0;
            weight_reg       <= '0;
            act_reg          <= '0;
            lane_idx         <= '0;
        end else begin
            state            <= state_nxt;
            done_out         <= done_nxt;
            weight_avail_out <= (state_nxt == LOAD_W);
            act_avail_out    <= (state_nxt == LOAD_A);
            valid_out        <= (state_nxt == OUT);
            if (configure) begin
                iters_cfg <= num_iters;
                reads_cfg <= num_reads_per_iter;
                sm_cfg    <= signed_mode;
                iter_cnt  <= '0;
                read_cnt  <= '0;
                lane_idx  <= '0;
            end else begin
                case (state)
                    LOAD_W: if (w_xfer) weight_reg <= weight_data_in;
                    LOAD_A: begin
                        if (a_xfer) begin
                            act_reg  <= act_data_in;
                            lane_idx <= '0;
                        end
                    end
                    MUL: begin
                        for (int j = 0; j < NUM_MULS; j++) begin
                            data_out[(int'(lane_idx) * NUM_MULS + j) * 2 * DATA_WIDTH +: 2 * DATA_WIDTH] <= prod[j];
                        end
                        lane_idx <= (lane_idx == LAST_LANE) ? '0 : lane_idx + LANE_ONE;
                    end
                    OUT: begin
                        if (o_xfer) begin
                            if (last_read) begin
                                read_cnt <= '0;
                                iter_cnt <= iter_cnt + ITER_ONE;
                            end else begin
                                read_cnt <= read_cnt + READ_ONE;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef MUL_BATCH_STATS_EN
    // Saturating beat and stall counters, cleared at the start of each run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else if (configure) begin
            stat_beats  <= '0;
            stat_stalls <= '0;
        end else begin
            if (o_xfer && stat_beats != 32'hFFFF_FFFF)
                stat_beats <= stat_beats + 32'd1;
            if (valid_out && !avail_in && stat_stalls != 32'hFFFF_FFFF)
                stat_stalls <= stat_stalls + 32'd1;
        end
    end
`endif

endmodule
